// File: rtl/decoupled_ser.sv
// decoupled_ser: width-down serializer, one wide valid/ready word out as BEATS narrow beats; DECOUPLED_SER_FLUSH_EN adds i_flush
module decoupled_ser #(
   parameter int NARROW_WIDTH = 32,
   parameter int BEATS        = 2,
   parameter bit MSB_FIRST    = 1'b0,
   localparam int BW          = (BEATS > 1) ? $clog2(BEATS) : 1,
   localparam int WW          = BEATS * NARROW_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
`ifdef DECOUPLED_SER_FLUSH_EN
   input  logic                    i_flush,
`endif
   input  logic                    i_wide_valid,
   output logic                    o_wide_ready,
   input  logic [WW-1:0]           i_wide_data,
   output logic                    o_narrow_valid,
   input  logic                    i_narrow_ready,
   output logic [NARROW_WIDTH-1:0] o_narrow_data,
   output logic                    o_last,
   output logic [BW-1:0]           o_beat
);
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_SEND = 1'b1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

   logic [0:0]    r_state;
   logic [BW-1:0] r_beat;
   logic [WW-1:0] r_hold;
   logic          w_flush;
   logic          w_live;
   logic          w_last_beat;
   logic          w_wide_fire;
   logic          w_narrow_fire;
   logic [BW-1:0] w_idx;

`ifdef DECOUPLED_SER_FLUSH_EN
   assign w_flush = i_flush;
`else
   assign w_flush = 1'b0;
`endif

   // reset and flush both silence the handshakes combinationally so no fire can slip through
   assign w_live      = rst && !w_flush;
   assign w_last_beat = (r_beat == LAST_BEAT);
   assign w_idx       = MSB_FIRST ? LAST_BEAT - r_beat : r_beat;

   // outputs: ready also on the last-beat fire so consecutive words run without a bubble
   always_comb begin
      o_narrow_valid = w_live && (r_state == S_SEND);
      o_last         = o_narrow_valid && w_last_beat;
      o_wide_ready   = w_live && ((r_state == S_IDLE) || (w_last_beat && i_narrow_ready));
      o_narrow_data  = r_hold[w_idx*NARROW_WIDTH +: NARROW_WIDTH];
      o_beat         = r_beat;
   end

   assign w_wide_fire   = i_wide_valid && o_wide_ready;
   assign w_narrow_fire = o_narrow_valid && i_narrow_ready;

   // control FSM: beat counter wraps explicitly at BEATS-1; a new word on the last beat stays in SEND
   always_ff @(posedge clk) begin
      if (!rst || w_flush) begin
         r_state <= S_IDLE;
         r_beat  <= '0;
      end else if (w_wide_fire) begin
         r_state <= S_SEND;
         r_beat  <= '0;
      end else if (w_narrow_fire) begin
         r_state <= w_last_beat ? S_IDLE : S_SEND;
         r_beat  <= w_last_beat ? '0 : r_beat + BW'(1);
      end
   end

   // hold register needs no reset; it is only read in SEND, which requires a fresh capture
   always_ff @(posedge clk) begin
      if (w_wide_fire) r_hold <= i_wide_data;
   end
endmodule

// File: tb/tb_decoupled_ser.sv
// tb_decoupled_ser: two serializer configurations in lockstep against a queue-of-beats reference model
module tb_decoupled_ser;
   localparam int NB [2] = '{2, 3};
   localparam bit MF [2] = '{1'b0, 1'b1};

   typedef struct {
      logic [31:0] d;
      logic        l;
      int          b;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        fl  = 1'b0;
   logic        wv  = 1'b0;
   logic        nr  = 1'b0;
   logic [95:0] wd  = '0;
   logic        wr_a, nv_a, l_a, wr_b, nv_b, l_b;
   logic [31:0] nd_a, nd_b;
   logic [0:0]  b_a;
   logic [1:0]  b_b;
   int          checks = 0;
   int          errors = 0;
   beat_t       q [2][$];

   always #5 clk = ~clk;

   decoupled_ser #(.NARROW_WIDTH(32), .BEATS(2), .MSB_FIRST(1'b0)) u_a (
      .clk(clk), .rst(rst),
`ifdef DECOUPLED_SER_FLUSH_EN
      .i_flush(fl),
`endif
      .i_wide_valid(wv), .o_wide_ready(wr_a), .i_wide_data(wd[63:0]),
      .o_narrow_valid(nv_a), .i_narrow_ready(nr), .o_narrow_data(nd_a),
      .o_last(l_a), .o_beat(b_a)
   );

   decoupled_ser #(.NARROW_WIDTH(32), .BEATS(3), .MSB_FIRST(1'b1)) u_b (
      .clk(clk), .rst(rst),
`ifdef DECOUPLED_SER_FLUSH_EN
      .i_flush(fl),
`endif
      .i_wide_valid(wv), .o_wide_ready(wr_b), .i_wide_data(wd),
      .o_narrow_valid(nv_b), .i_narrow_ready(nr), .o_narrow_data(nd_b),
      .o_last(l_b), .o_beat(b_b)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      assert (act === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
      end
   endtask

   // checks outputs against the model mid-cycle, then advances the model across one posedge
   task automatic cycle();
      logic fw [2];
      logic fn [2];
      #2;
      for (int k = 0; k < 2; k++) begin
         logic ev, er, el;
         logic [31:0] ed;
         int eb;
         string s;
         s  = $sformatf("dut%0d@%0t", k, $time);
         ev = rst && !fl && q[k].size() > 0;
         er = rst && !fl && (q[k].size() == 0 || (q[k].size() == 1 && nr));
         el = ev && q[k][0].l;
         ed = ev ? q[k][0].d : 32'h0;
         eb = q[k].size() > 0 ? q[k][0].b : 0;
         chk({s, " valid"}, 32'(k ? nv_b : nv_a), 32'(ev));
         chk({s, " ready"}, 32'(k ? wr_b : wr_a), 32'(er));
         chk({s, " last"},  32'(k ? l_b : l_a),   32'(el));
         if (ev) chk({s, " data"}, k ? nd_b : nd_a, ed);
         if (rst && !fl) chk({s, " beat"}, k ? 32'(b_b) : 32'(b_a), 32'(eb));
         fw[k] = er && wv;
         fn[k] = ev && nr;
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (!rst || fl) q[k].delete();
         else begin
            if (fn[k]) void'(q[k].pop_front());
            if (fw[k])
               for (int j = 0; j < NB[k]; j++) begin
                  int sl;
                  sl = MF[k] ? NB[k] - 1 - j : j;
                  q[k].push_back('{wd[sl*32 +: 32], j == NB[k] - 1, j});
               end
         end
      end
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      // reset two cycles, then idle
      run(2);
      rst = 1'b1;
      run(1);
      // basic split; dut1 sees 0x3 on its top slice
      wd = {32'h3, 64'hAAAA_BBBB_1111_2222};
      wv = 1'b1; nr = 1'b1;
      run(1);
      wv = 1'b0;
      run(4);
      // three-beat MSB-first word
      wd = 96'h0000_0003_0000_0002_0000_0001;
      wv = 1'b1;
      run(1);
      wv = 1'b0;
      run(4);
      // back-to-back words with continuous ready
      wv = 1'b1;
      for (int i = 0; i < 10; i++) begin
         wd = {$urandom, $urandom, $urandom};
         run(1);
      end
      wv = 1'b0;
      run(3);
      // backpressure on beat 0
      wd = {$urandom, $urandom, $urandom};
      wv = 1'b1;
      run(1);
      wv = 1'b0; nr = 1'b0;
      run(3);
      nr = 1'b1;
      run(4);
      // reset after beat 0 fires, then a fresh word
      wd = {$urandom, $urandom, $urandom};
      wv = 1'b1;
      run(1);
      wv = 1'b0;
      run(1);
      rst = 1'b0;
      run(1);
      rst = 1'b1;
      run(2);
      wd = {$urandom, $urandom, $urandom};
      wv = 1'b1;
      run(1);
      wv = 1'b0;
      run(4);
`ifdef DECOUPLED_SER_FLUSH_EN
      wd = {$urandom, $urandom, $urandom};
      wv = 1'b1;
      run(1);
      wv = 1'b0;
      run(1);
      fl = 1'b1;
      run(1);
      fl = 1'b0;
      run(2);
      wd = {$urandom, $urandom, $urandom};
      wv = 1'b1;
      run(1);
      wv = 1'b0;
      run(4);
`endif
      // randomized traffic with occasional reset
      for (int i = 0; i < 400; i++) begin
         wd  = {$urandom, $urandom, $urandom};
         wv  = $urandom_range(0, 3) != 0;
         nr  = $urandom_range(0, 3) != 0;
         rst = $urandom_range(0, 49) != 0;
`ifdef DECOUPLED_SER_FLUSH_EN
         fl  = $urandom_range(0, 39) == 0;
`endif
         run(1);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
